// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants and types for pipelined_addsub.
//   ADDSUB_ADD / ADDSUB_SUB : values of the sel input
//   flags_t                 : writeback flag bundle {c_out, overflow, zero, negative}
package addsub_pkg;
  localparam logic ADDSUB_ADD = 1'b0;
  localparam logic ADDSUB_SUB = 1'b1;
  typedef struct packed {
    logic c_out;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;
endpackage

// File: rtl/addsub_segment.sv
// addsub_segment: combinational SEG-bit ripple-carry adder slice.
//   a, b : SEG-bit addends
//   cin  : carry into bit 0
//   s    : SEG-bit partial sum
//   cout : carry out of bit SEG-1
//   cmsb : carry into bit SEG-1 (overflow tap)
module addsub_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           cmsb
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  // sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly
  assign cmsb = a[SEG-1] ^ b[SEG-1] ^ s[SEG-1];
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract with the carry chain cut into
// SEG-bit pipeline stages, valid/ready handshake with global stall, and flags.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : operand handshake
//   x, y, sel            : operands; sel = 0 add, 1 subtract (x - y)
//   out_valid, out_ready : result handshake
//   sum                  : result modulo 2^WIDTH
//   c_out, overflow      : raw carry out of MSB, signed overflow
//   zero, negative       : sum == 0, sum[WIDTH-1]
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int STAGES = WIDTH / SEG;
  if (WIDTH % SEG != 0 || WIDTH < 2) begin : g_bad
    $fatal(1, "pipelined_addsub: WIDTH must be a multiple of SEG and at least 2");
  end
  logic             advance;
  logic             last_co;
  logic             last_cm;
  logic [WIDTH-1:0] last_sn;
  flags_t           flags;
  // the whole pipe moves as one; nothing loads while the output is blocked
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    // xa/ya: operand bits not yet consumed, this stage's segment at the bottom
    logic [WIDTH-LO-1:0] xa;
    logic [WIDTH-LO-1:0] ya;
    // sn/s: completed low sum bits including this segment (comb / registered)
    logic [LO+SEG-1:0]   sn;
    logic [LO+SEG-1:0]   s;
    logic [SEG-1:0]      ps;
    logic                vi;
    logic                ci;
    logic                co;
    logic                cmsb;
    logic                v;
    if (k == 0) begin : g_src
      assign vi = in_valid;
      assign xa = x;
      assign ya = y ^ {WIDTH{sel == ADDSUB_SUB}};
      assign ci = sel == ADDSUB_SUB;
      assign sn = ps;
    end else begin : g_src
      assign vi = g_stage[k-1].v;
      assign xa = g_stage[k-1].g_fwd.xs;
      assign ya = g_stage[k-1].g_fwd.ys;
      assign ci = g_stage[k-1].g_fwd.c;
      assign sn = {ps, g_stage[k-1].s};
    end
    addsub_segment #(.SEG(SEG)) u_seg (
      .a   (xa[SEG-1:0]),
      .b   (ya[SEG-1:0]),
      .cin (ci),
      .s   (ps),
      .cout(co),
      .cmsb(cmsb)
    );
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v <= 1'b0;
        s <= '0;
      end else if (advance) begin
        v <= vi;
        s <= sn;
      end
    // every stage but the last forwards the remaining operand bits and its carry
    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-LO-SEG-1:0] xs;
      logic [WIDTH-LO-SEG-1:0] ys;
      logic                    c;
      logic                    unused_cmsb;
      assign unused_cmsb = cmsb;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          xs <= '0;
          ys <= '0;
          c  <= 1'b0;
        end else if (advance) begin
          xs <= xa[WIDTH-LO-1:SEG];
          ys <= ya[WIDTH-LO-1:SEG];
          c  <= co;
        end
    end
  end
  assign last_co = g_stage[STAGES-1].co;
  assign last_cm = g_stage[STAGES-1].cmsb;
  assign last_sn = g_stage[STAGES-1].sn;
  // flags are registered alongside the final sum so they stay in step with it
  always_ff @(posedge clk or posedge rst)
    if (rst) flags <= '0;
    else if (advance) flags <= '{c_out: last_co, overflow: last_co ^ last_cm, zero: last_sn == '0, negative: last_sn[WIDTH-1]};
  assign out_valid = g_stage[STAGES-1].v;
  assign sum       = g_stage[STAGES-1].s;
  assign {c_out, overflow, zero, negative} = flags;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench for pipelined_addsub (16/4 and 6/2 builds).
module tb_pipelined_addsub;
  localparam int W = 16;
  localparam int S = 4;
  localparam int N = W / S;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_ready, sel, out_valid, out_ready, c_out, overflow, zero, negative;
  logic [W-1:0] x, y, sum;
  logic in_valid_b, in_ready_b, sel_b, out_valid_b, c_out_b, overflow_b, zero_b, negative_b;
  logic out_ready_b;
  logic [5:0] x_b, y_b, sum_b;
  int checks = 0;
  int errors = 0;
  bit rnd_on = 1'b0;
  typedef struct packed {
    logic [15:0] s;
    logic [3:0]  f;
  } res_t;
  res_t exp_q[$];

  pipelined_addsub #(.WIDTH(W), .SEG(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out),
    .overflow(overflow), .zero(zero), .negative(negative)
  );
  pipelined_addsub #(.WIDTH(6), .SEG(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .x(x_b), .y(y_b), .sel(sel_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .sum(sum_b), .c_out(c_out_b),
    .overflow(overflow_b), .zero(zero_b), .negative(negative_b)
  );

  // reference: plain integer arithmetic on the unsigned and signed readings
  function automatic res_t model(int w, longint a, longint b, logic sub);
    longint m  = longint'(1) << w;
    longint sa = a >= m / 2 ? a - m : a;
    longint sb = b >= m / 2 ? b - m : b;
    longint u  = sub ? a - b : a + b;
    longint sr = sub ? sa - sb : sa + sb;
    longint r  = ((u % m) + m) % m;
    res_t t;
    t.s = 16'(r);
    t.f = {sub ? a >= b : u >= m, sr >= m / 2 || sr < -(m / 2), r == 0, r >= m / 2};
    return t;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic send(logic [15:0] a, logic [15:0] b, logic s);
    bit done = 1'b0;
    x = a;
    y = b;
    sel = s;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(W, a, b, s));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send: in_ready stayed low");
    end
    in_valid = 1'b0;
  endtask

  // single transaction into an empty pipe with out_ready high
  task automatic dir(logic [15:0] a, logic [15:0] b, logic s, logic [15:0] es, logic [3:0] ef);
    fork
      send(a, b, s);
      for (int i = 0; i <= N; i++) begin
        @(negedge clk);
        chk("latency_valid", out_valid, i == N);
        if (i == N) begin
          chk("dir_sum", sum, es);
          chk("dir_flags", {c_out, overflow, zero, negative}, ef);
        end
      end
    join
    @(posedge clk);
    #1;
  endtask

  task automatic dirb(logic [5:0] a, logic [5:0] b, logic s, logic [5:0] es, logic [3:0] ef);
    res_t m = model(6, a, b, s);
    x_b = a;
    y_b = b;
    sel_b = s;
    in_valid_b = 1'b1;
    #1 chk("b_in_ready", in_ready_b, 1);
    @(posedge clk);
    #1 in_valid_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("b_valid", out_valid_b, 1);
    chk("b_sum", sum_b, es);
    chk("b_flags", {c_out_b, overflow_b, zero_b, negative_b}, ef);
    chk("b_model_sum", sum_b, m.s[5:0]);
    chk("b_model_flags", {c_out_b, overflow_b, zero_b, negative_b}, m.f);
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #1 out_ready = rnd_on ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: handshake rule, stall stability, in-order results
  initial begin
    bit held;
    res_t hv, e;
    forever begin
      @(negedge clk);
      if (rst) held = 1'b0;
      else begin
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        if (held) chk("stall_hold", {sum, c_out, overflow, zero, negative}, hv);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: sum %0h with empty scoreboard", sum);
          end else begin
            e = exp_q.pop_front();
            chk("result", {sum, c_out, overflow, zero, negative}, e);
          end
        end
        held = out_valid && !out_ready;
        hv = {sum, c_out, overflow, zero, negative};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    x = '0;
    y = '0;
    sel = 1'b0;
    out_ready = 1'b1;
    out_ready_b = 1'b1;
    in_valid_b = 1'b0;
    x_b = '0;
    y_b = '0;
    sel_b = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_flags", {c_out, overflow, zero, negative}, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    dir(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101);
    dir(16'h1234, 16'h1234, 1'b1, 16'h0000, 4'b1010);
    dir(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b0001);
    dir(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 4'b0000);
    dir(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1010);
    dir(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1100);
    // back-to-back stream: exactly 8 consecutive valid cycles after latency N
    fork
      for (int i = 0; i < 8; i++) send(pick(), pick(), 1'(i % 2));
      for (int i = 0; i <= N + 8; i++) begin
        @(negedge clk);
        chk("stream_valid", out_valid, i >= N && i < N + 8);
      end
    join
    @(posedge clk);
    #1;
    // random backpressure
    rnd_on = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(pick(), pick(), 1'($urandom_range(0, 1)));
    end
    rnd_on = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    #1 chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
    // reset with three transactions in flight
    for (int i = 0; i < 3; i++) send(pick(), pick(), 1'(i % 2));
    @(posedge clk);
    #1 chk("pre_reset_valid", out_valid, 1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midreset_valid", out_valid, 0);
    chk("midreset_sum", sum, 0);
    chk("midreset_flags", {c_out, overflow, zero, negative}, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("postreset_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_out", out_valid, 0);
    end
    @(posedge clk);
    #1;
    dirb(6'b011111, 6'b000001, 1'b0, 6'b100000, 4'b0101);
    dirb(6'b111111, 6'b000001, 1'b0, 6'b000000, 4'b1010);
    dirb(6'b100000, 6'b000001, 1'b1, 6'b011111, 4'b1100);
    dirb(6'b010101, 6'b010101, 1'b1, 6'b000000, 4'b1010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
